sha256_msg_schedule: RTL

SHA256_MSG_SCHEDULE -- requirements
Module: sha256_msg_schedule

---
 rtl/sha256_pkg.sv | 33 +++
 rtl/sha256_sigma.sv | 33 +++
 rtl/sha256_msg_schedule.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/sha256_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sha256_pkg
// Description : Shared types and constants for the SHA-256 message schedule:
//               FSM state encoding, round constants, the 32-bit word type
//               and a byte-reversal helper.
// Revision    : 1.0 - initial release
// ============================================================================
package sha256_pkg;

    // 32-bit SHA-256 word
    typedef logic [31:0] word_t;

    // Schedule FSM encoding
    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        ROUND0TO15  = 2'd1,
        ROUND16TO63 = 2'd2,
        DONE        = 2'd3
    } state_t;

    // Index of the last schedule word
    localparam int unsigned ROUND_LAST = 63;
    // Number of message words per 512-bit block (also the window depth)
    localparam int unsigned MSG_WORDS  = 16;

    // Reverse the byte order of a word
    function automatic word_t byte_swap(input word_t x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

endpackage : sha256_pkg
`default_nettype wire

// File: rtl/sha256_sigma.sv
`default_nettype none
// ============================================================================
// Module      : sha256_sigma
// Description : Combinational SHA-256 small sigma function.
//               SEL = 0 : sigma0 = ROTR7  ^ ROTR18 ^ SHR3
//               SEL = 1 : sigma1 = ROTR17 ^ ROTR19 ^ SHR10
// Revision    : 1.0 - initial release
// ============================================================================
module sha256_sigma
    import sha256_pkg::*;
#(
    parameter int SEL = 0
) (
    input  logic [31:0] i_x,
    output logic [31:0] o_y
);

    generate
        if (SEL == 0) begin : g_sigma0
            // sigma0 used on W[t-15]
            assign o_y = {i_x[6:0],  i_x[31:7]}  ^
                         {i_x[17:0], i_x[31:18]} ^
                         {3'b000,    i_x[31:3]};
        end else begin : g_sigma1
            // sigma1 used on W[t-2]
            assign o_y = {i_x[16:0], i_x[31:17]} ^
                         {i_x[18:0], i_x[31:19]} ^
                         {10'b0,     i_x[31:10]};
        end
    endgenerate

endmodule : sha256_sigma
`default_nettype wire

// File: rtl/sha256_msg_schedule.sv
`default_nettype none
// ============================================================================
// Module      : sha256_msg_schedule
// Description : SHA-256 message schedule generator. Passes message words
//               M[0..15] straight through to the compression stage while
//               capturing them in a 16-entry sliding window, then expands
//               W[16..63] from that window one word per accepted transfer.
//               Optional build macro: SHA256_WORD_SWAP_EN - byte-reverse
//               word_in before it reaches w_out and the window.
// Revision    : 1.0 - initial release
// ============================================================================
module sha256_msg_schedule
    import sha256_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        start_in,
    input  logic [31:0] word_in,
    input  logic        word_valid_in,
    output logic        word_ready_out,
    output logic [31:0] w_out,
    output logic        w_valid_out,
    input  logic        w_ready_in,
    output logic [6:0]  round_out,
    output logic        busy_out,
    output logic        done_out
);

    // Round indices at which the FSM leaves each round phase
    localparam logic [6:0] c_MSG_LAST   = 7'(MSG_WORDS - 1);
    localparam logic [6:0] c_ROUND_LAST = 7'(ROUND_LAST);

    state_t      r_state;
    logic [6:0]  r_round;
    // r_win[0] holds W[t-1], r_win[15] holds W[t-16]
    word_t       r_win [MSG_WORDS];

    word_t       w_word;
    word_t       w_s0;
    word_t       w_s1;
    word_t       w_sched;
    logic        w_xfer_msg;
    logic        w_xfer_sched;

`ifdef SHA256_WORD_SWAP_EN
    assign w_word = byte_swap(word_in);
`else
    assign w_word = word_in;
`endif

    sha256_sigma #(.SEL(0)) u_sigma0 (
        .i_x (r_win[14]),
        .o_y (w_s0)
    );

    sha256_sigma #(.SEL(1)) u_sigma1 (
        .i_x (r_win[1]),
        .o_y (w_s1)
    );

    // W[t] = sigma1(W[t-2]) + W[t-7] + sigma0(W[t-15]) + W[t-16], mod 2^32
    assign w_sched = w_s1 + r_win[6] + w_s0 + r_win[15];

    assign w_xfer_msg   = (r_state == ROUND0TO15)  && word_valid_in && w_ready_in;
    assign w_xfer_sched = (r_state == ROUND16TO63) && w_ready_in;

    // Output datapath: pass-through for message words, expansion afterwards
    always_comb begin
        w_out          = '0;
        w_valid_out    = 1'b0;
        word_ready_out = 1'b0;
        round_out      = '0;
        case (r_state)
            ROUND0TO15: begin
                w_out          = w_word;
                w_valid_out    = word_valid_in;
                word_ready_out = w_ready_in;
                round_out      = r_round;
            end
            ROUND16TO63: begin
                w_out          = w_sched;
                w_valid_out    = 1'b1;
                round_out      = r_round;
            end
            default: ;
        endcase
    end

    assign busy_out = (r_state != IDLE);
    assign done_out = (r_state == DONE);

    // FSM, round counter and window shift; window only moves on a transfer
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= IDLE;
            r_round <= '0;
            for (int i = 0; i < int'(MSG_WORDS); i++) begin
                r_win[i] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    r_round <= '0;
                    if (start_in) begin
                        r_state <= ROUND0TO15;
                    end
                end
                ROUND0TO15: begin
                    if (w_xfer_msg) begin
                        r_win[0] <= w_word;
                        for (int i = 1; i < int'(MSG_WORDS); i++) begin
                            r_win[i] <= r_win[i-1];
                        end
                        r_round <= r_round + 7'd1;
                        if (r_round == c_MSG_LAST) begin
                            r_state <= ROUND16TO63;
                        end
                    end
                end
                ROUND16TO63: begin
                    if (w_xfer_sched) begin
                        r_win[0] <= w_sched;
                        for (int i = 1; i < int'(MSG_WORDS); i++) begin
                            r_win[i] <= r_win[i-1];
                        end
                        if (r_round == c_ROUND_LAST) begin
                            r_state <= DONE;
                            r_round <= '0;
                        end else begin
                            r_round <= r_round + 7'd1;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_round <= '0;
                end
                default: begin
                    r_state <= IDLE;
                    r_round <= '0;
                end
            endcase
        end
    end

endmodule : sha256_msg_schedule
`default_nettype wire
